// File: rtl/bram_byte_en.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read data is registered (one cycle of latency) and write-first: a word
// written at an edge appears, already merged, on data_out after that edge.
// Only the output register is reset; the storage array keeps its contents.
module bram_byte_en #(
  parameter int    AddressBitwidth = 10,
  parameter string DataFilePath    = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 write_enable,
  input  logic [AddressBitwidth-1:0] address,
  input  logic [31:0]                data_in,
  output logic [31:0]                data_out
);

  localparam int Depth = 2 ** AddressBitwidth;

  logic [31:0] mem [Depth];

  // Current stored word and the word as it will look after this edge's write.
  logic [31:0] stored_word;
  logic [31:0] merged_word;
  logic [31:0] data_out_reg;

  assign stored_word = mem[address];

  // Per-lane merge: enabled lanes take the new byte, others keep the old one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = write_enable[gi] ? data_in[gi*8 +: 8]
                                                       : stored_word[gi*8 +: 8];
    end
  endgenerate

  // Byte-lane writes; a write while rst_n is low is discarded.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (write_enable[b]) begin
          mem[address][b*8 +: 8] <= data_in[b*8 +: 8];
        end
      end
    end
  end

  // Output register: cleared asynchronously, otherwise loads the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= 32'h0;
    end else begin
      data_out_reg <= merged_word;
    end
  end

  assign data_out = data_out_reg;

endmodule

// File: tb/tb_bram_byte_en.sv
// Randomised self-checking bench for bram_byte_en against a word-array model.
module tb_bram_byte_en;

  localparam int AW    = 10;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    write_enable = 4'h0;
  logic [AW-1:0] address = '0;
  logic [31:0]   data_in = 32'h0;
  logic [31:0]   data_out;

  bram_byte_en #(.AddressBitwidth(AW), .DataFilePath("")) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [DEPTH];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock of stimulus; expected value follows the write-first rule.
  task automatic do_cycle(input logic [3:0] we, input logic [AW-1:0] a,
                          input logic [31:0] d, input string tag);
    logic [31:0] exp;
    write_enable = we;
    address      = a;
    data_in      = d;
    @(posedge clk);
    if (rst_n) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
      exp = model_mem[a];
    end else begin
      exp = 32'h0;
    end
    #1;
    check_val(tag, data_out, exp);
    $display("txn %-10s we=%h addr=%03h din=%08h dout=%08h", tag, we, a, d, data_out);
  endtask

  initial begin
    // Reset state
    #3 check_val("rst_init", data_out, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Prior value at 7, then reset/write scenario from the plan
    do_cycle(4'hF, 7, 32'h7777_0007, "wr7");
    do_cycle(4'hF, 5, 32'h1122_3344, "wr5");
    do_cycle(4'hF, 9, 32'hDEAD_BEEF, "deadbeef");
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", data_out, 32'h0);
    do_cycle(4'hF, 7, 32'hFFFF_FFFF, "rst_wr");
    do_cycle(4'hF, 7, 32'hFFFF_FFFF, "rst_wr2");
    #2 rst_n = 1'b1;
    do_cycle(4'h0, 7, 32'h0, "rd7_prior");
    check_val("rd7_const", data_out, 32'h7777_0007);

    // Byte merge
    do_cycle(4'h0, 5, 32'h0, "rd5");
    check_val("rd5_const", data_out, 32'h1122_3344);
    do_cycle(4'b0101, 5, 32'hAABB_CCDD, "merge");
    check_val("merge_const", data_out, 32'h11BB_33DD);
    do_cycle(4'h0, 5, 32'h0, "merge_rd");
    check_val("merge_rd_c", data_out, 32'h11BB_33DD);

    // Write-first
    do_cycle(4'hF, 10'h3F, 32'h1234_5678, "pre3f");
    do_cycle(4'hF, 10'h3F, 32'h0000_0042, "wfirst");
    check_val("wfirst_c", data_out, 32'h0000_0042);

    // Latency and isolation, including top address vs address 0
    for (int k = 0; k < 8; k++) do_cycle(4'hF, AW'(k), 32'hA0 + k, "fill");
    do_cycle(4'hF, AW'(DEPTH - 1), 32'h5A5A_0FFF, "top");
    for (int k = 0; k < 8; k++) do_cycle(4'h0, AW'(k), $urandom, "seqrd");
    do_cycle(4'h0, 0, 32'h0, "alias0");
    check_val("alias0_c", data_out, 32'h0000_00A0);
    do_cycle(4'h0, AW'(DEPTH - 1), 32'h0, "aliastop");
    check_val("aliastop_c", data_out, 32'h5A5A_0FFF);

    // Back-to-back partial writes to the same address
    do_cycle(4'b0001, 3, 32'h0000_0011, "b2b0");
    do_cycle(4'b0010, 3, 32'h0000_2200, "b2b1");
    do_cycle(4'b1000, 3, 32'h4400_0000, "b2b2");
    check_val("b2b_c", data_out, 32'h4400_2211);

    // we=0 hold with random data_in
    for (int k = 0; k < 10; k++) do_cycle(4'h0, 2, $urandom, "hold");

    // Randomised traffic over initialised addresses 0..15
    for (int k = 8; k < 16; k++) do_cycle(4'hF, AW'(k), $urandom, "init");
    for (int k = 0; k < 200; k++)
      do_cycle(4'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom, "rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
